// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch engine: run-state encoding and BCD digit type.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } sw_state_t;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/stopwatch_core_bcd_addsub.sv
// Combinational packed-BCD increment/decrement by 1 or 10 with ripple carry/borrow.
module bcd_addsub
  import stopwatch_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] value,
  input  logic                step10,
  input  logic                dir,
  output logic [4*DIGITS-1:0] result,
  output logic                carry_out,
  output logic                underflow
);

  logic [4*DIGITS-1:0] w_res;
  logic                w_c;
  logic [4:0]          w_t;
  logic [4:0]          w_add;
  bcd_digit_t          w_digit;

  // Digit-serial ripple: the step lands on digit 0 (x1) or digit 1 (x10).
  always_comb begin
    w_res   = {4*DIGITS{1'b0}};
    w_c     = 1'b0;
    w_t     = 5'd0;
    w_add   = 5'd0;
    w_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      w_digit = value[4*i +: 4];
      w_add   = (((i == 0) && !step10) || ((i == 1) && step10)) ? 5'd1 : 5'd0;
      if (!dir) begin
        w_t = {1'b0, w_digit} + w_add + {4'd0, w_c};
        if (w_t >= 5'd10) begin
          w_t = w_t - 5'd10;
          w_c = 1'b1;
        end else begin
          w_c = 1'b0;
        end
      end else begin
        w_t = {1'b0, w_digit} - w_add - {4'd0, w_c};
        if (w_t[4]) begin
          w_t = w_t + 5'd10;
          w_c = 1'b1;
        end else begin
          w_c = 1'b0;
        end
      end
      w_res[4*i +: 4] = w_t[3:0];
    end
    result    = w_res;
    carry_out = !dir && w_c;
    // Reaching exactly zero also counts as expiry: value <= step.
    underflow = dir && (w_c || (w_res == {4*DIGITS{1'b0}}));
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch/countdown engine: run FSM, tick divider, BCD count, lap capture and event pulses.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_p,
  input  logic                pause_p,
  input  logic                clear_p,
  input  logic                lap_p,
  input  logic                load_en,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                dir,
  input  logic                step10,
  output logic [4*DIGITS-1:0] count,
  output logic [4*DIGITS-1:0] lap,
  output logic                lap_valid,
  output logic [1:0]          state,
  output logic                tick,
  output logic                wrap,
  output logic                done
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4*DIGITS-1:0] ZERO_CNT = {4*DIGITS{1'b0}};

  sw_state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0]    r_div, w_div_nxt;
  logic [4*DIGITS-1:0] r_count, w_count_nxt;
  logic [4*DIGITS-1:0] r_lap, w_lap_nxt;
  logic                r_lap_valid, w_lap_valid_nxt;
  logic                r_dir, w_dir_nxt;
  logic                r_wrap, w_wrap_nxt;
  logic                r_done, w_done_nxt;

  logic                w_tick;
  logic                w_load_ok;
  logic [4*DIGITS-1:0] w_sum;
  logic                w_carry;
  logic                w_under;

  bcd_addsub #(.DIGITS(DIGITS)) u_addsub (
    .value     (r_count),
    .step10    (step10),
    .dir       (r_dir),
    .result    (w_sum),
    .carry_out (w_carry),
    .underflow (w_under)
  );

  assign w_tick    = (r_state == ST_RUN) && (r_div == DIV_LAST);
  assign w_load_ok = load_en && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Next-state logic: clear > load > start > pause; lap is independent but loses to clear.
  always_comb begin
    w_state_nxt     = r_state;
    w_div_nxt       = r_div;
    w_count_nxt     = r_count;
    w_lap_nxt       = r_lap;
    w_lap_valid_nxt = r_lap_valid;
    w_dir_nxt       = r_dir;
    w_wrap_nxt      = 1'b0;
    w_done_nxt      = 1'b0;

    if (lap_p && ((r_state == ST_RUN) || (r_state == ST_PAUSE))) begin
      w_lap_nxt       = r_count;
      w_lap_valid_nxt = 1'b1;
    end else begin
      w_lap_nxt       = r_lap;
    end

    if (clear_p) begin
      w_state_nxt     = ST_IDLE;
      w_div_nxt       = {DIV_W{1'b0}};
      w_count_nxt     = ZERO_CNT;
      w_lap_nxt       = ZERO_CNT;
      w_lap_valid_nxt = 1'b0;
    end else if (w_load_ok) begin
      w_count_nxt = load_val;
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_p && dir && (r_count == ZERO_CNT)) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else if (start_p) begin
            w_state_nxt = ST_RUN;
            w_dir_nxt   = dir;
            w_div_nxt   = {DIV_W{1'b0}};
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          w_div_nxt = w_tick ? {DIV_W{1'b0}} : (r_div + {{(DIV_W-1){1'b0}}, 1'b1});
          if (pause_p) begin
            w_state_nxt = ST_PAUSE;
          end else begin
            w_state_nxt = ST_RUN;
          end
          // Expiry overrides a coincident pause: the count is already at zero.
          if (w_tick && r_dir && w_under) begin
            w_count_nxt = ZERO_CNT;
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else if (w_tick) begin
            w_count_nxt = w_sum;
            w_wrap_nxt  = w_carry;
          end else begin
            w_count_nxt = r_count;
          end
        end
        ST_PAUSE: begin
          if (start_p) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_PAUSE;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_div_nxt   = {DIV_W{1'b0}};
        end
      endcase
    end
  end

  // State, divider, count, lap and event-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_div       <= {DIV_W{1'b0}};
      r_count     <= ZERO_CNT;
      r_lap       <= ZERO_CNT;
      r_lap_valid <= 1'b0;
      r_dir       <= 1'b0;
      r_wrap      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_div       <= w_div_nxt;
      r_count     <= w_count_nxt;
      r_lap       <= w_lap_nxt;
      r_lap_valid <= w_lap_valid_nxt;
      r_dir       <= w_dir_nxt;
      r_wrap      <= w_wrap_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign count     = r_count;
  assign lap       = r_lap;
  assign lap_valid = r_lap_valid;
  assign state     = r_state;
  assign tick      = w_tick;
  assign wrap      = r_wrap;
  assign done      = r_done;

endmodule
